mem_access_stage: RTL and testbench

- MEM stage of the pipelined ARMv8 core. Sits directly downstream of EX and upstream of register-file writeback.
- Consumes EX/MEM control and ALU result; executes LDUR/STUR against an internal 64-bit word-addressed data memory.
- Registers the MEM/WB pipeline outputs with 1-cycle latency.
- Memory array is named `memory` so benches can preload it with $readmemh.

---
 rtl/arm_pkg.sv | 28 ++
 rtl/data_memory_array.sv | 35 +++
 rtl/mem_access_stage.sv | 140 ++++++++++++++
 tb/tb_mem_access_stage.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
`default_nettype none
// =============================================================================
// arm_pkg : shared datapath width, zero-register index and pipeline slot types
// Revision: 1.0
// =============================================================================
package arm_pkg;

    localparam int         DATA_W = 64;
    localparam logic [4:0] REG_ZR = 5'd31;

    typedef struct packed {
        logic       valid;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic [4:0] rd;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [4:0]        rd;
        logic [DATA_W-1:0] value;
    } mem_wb_t;

endpackage
`default_nettype wire

// File: rtl/data_memory_array.sv
`default_nettype none
// =============================================================================
// data_memory_array : single-port DEPTH x DATA_W array, registered read-before-write
// Revision: 1.0
// =============================================================================
module data_memory_array #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] memory [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read samples the old word even when a write hits the same index this edge.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= memory[addr_i];
        end
        if (we_i) begin
            memory[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// =============================================================================
// mem_access_stage : MEM pipeline stage executing LDUR/STUR, registers MEM/WB slot
// Optional macro DMEM_BOUNDS_CHECK_EN adds a sticky out-of-range `fault` output.
// Revision: 1.0
// =============================================================================
module mem_access_stage
    import arm_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = arm_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    input  logic              ex_mem_to_reg,
    input  logic [4:0]        ex_rd,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              stall,
    input  logic              flush,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_value,
    output logic [DATA_W-1:0] wb_read_data,
`ifdef DMEM_BOUNDS_CHECK_EN
    output logic              fault,
`endif
    output logic [15:0]       store_count
);

    ex_mem_ctrl_t      w_ctrl;
    logic              w_act;
    logic              w_both;
    logic              w_oob;
    logic              w_store_en;
    logic              w_load_en;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_load_data;

    mem_wb_t           wb_d, wb_q;
    logic              mem_to_reg_d, mem_to_reg_q;
    logic              load_d, load_q;
    logic [15:0]       store_count_q;

    assign w_ctrl = '{valid:      ex_valid,
                      mem_read:   ex_mem_read,
                      mem_write:  ex_mem_write,
                      reg_write:  ex_reg_write,
                      mem_to_reg: ex_mem_to_reg,
                      rd:         ex_rd};

    assign w_act  = w_ctrl.valid & ~flush & ~stall;
    assign w_both = w_ctrl.mem_read & w_ctrl.mem_write;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign w_oob = (w_ctrl.mem_read | w_ctrl.mem_write) & (ex_alu_result >= DATA_W'(DEPTH));
`else
    assign w_oob = 1'b0;
`endif

    // A combined read+write is executed as a store only.
    assign w_store_en = w_act & w_ctrl.mem_write & ~w_oob;
    assign w_load_en  = w_act & w_ctrl.mem_read & ~w_ctrl.mem_write & ~w_oob;

    data_memory_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clock),
        .we_i    (w_store_en & ~reset),
        .re_i    (w_load_en),
        .addr_i  (ex_alu_result[ADDR_W-1:0]),
        .wdata_i (ex_store_data),
        .rdata_o (w_rdata)
    );

    always_comb begin
        wb_d         = '0;
        mem_to_reg_d = 1'b0;
        load_d       = 1'b0;
        if (w_act) begin
            wb_d.valid     = 1'b1;
            wb_d.reg_write = w_ctrl.reg_write & (w_ctrl.rd != REG_ZR) & ~w_both & ~w_oob;
            wb_d.rd        = w_ctrl.rd;
            wb_d.value     = ex_alu_result;
            mem_to_reg_d   = w_ctrl.mem_to_reg;
            load_d         = w_load_en;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wb_q          <= '0;
            mem_to_reg_q  <= 1'b0;
            load_q        <= 1'b0;
            store_count_q <= '0;
        end else begin
            if (!stall) begin
                wb_q         <= wb_d;
                mem_to_reg_q <= mem_to_reg_d;
                load_q       <= load_d;
            end
            if (w_store_en) begin
                store_count_q <= store_count_q + 16'd1;
            end
        end
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    logic fault_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (w_act & w_oob) begin
            fault_q <= 1'b1;
        end
    end

    assign fault = fault_q;
`endif

    // The array's read register holds stale words between loads; load_q masks them.
    assign w_load_data  = load_q ? w_rdata : '0;
    assign wb_valid     = wb_q.valid;
    assign wb_reg_write = wb_q.reg_write;
    assign wb_rd        = wb_q.rd;
    assign wb_read_data = w_load_data;
    assign wb_value     = mem_to_reg_q ? w_load_data : wb_q.value;
    assign store_count  = store_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// =============================================================================
// tb_mem_access_stage : directed stimulus with a cycle-tagged expectation queue
// Revision: 1.0
// =============================================================================
module tb_mem_access_stage;

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    typedef struct {
        logic        rst, v, mr, mw, rw, m2r;
        logic [4:0]  rd;
        logic [63:0] alu, sd;
        logic        st, fl;
    } stim_t;

    typedef struct {
        int          due;
        logic        v, rw;
        logic [4:0]  rd;
        logic [63:0] val, rdata;
        logic [15:0] sc;
        logic        flt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
    logic [4:0]  ex_rd;
    logic [63:0] ex_alu_result, ex_store_data;
    logic        stall, flush;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [63:0] wb_value, wb_read_data;
    logic [15:0] store_count;
`ifdef DMEM_BOUNDS_CHECK_EN
    logic        fault;
`endif

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    exp_t q[$];

    mem_access_stage dut (
        .clock         (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_rd         (ex_rd),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .stall         (stall),
        .flush         (flush),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_value      (wb_value),
        .wb_read_data  (wb_read_data),
`ifdef DMEM_BOUNDS_CHECK_EN
        .fault         (fault),
`endif
        .store_count   (store_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops the expectation due for the edge just taken.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            cmp("wb_valid",     64'(wb_valid),     64'(e.v));
            cmp("wb_reg_write", 64'(wb_reg_write), 64'(e.rw));
            cmp("wb_rd",        64'(wb_rd),        64'(e.rd));
            cmp("wb_value",     wb_value,          e.val);
            cmp("wb_read_data", wb_read_data,      e.rdata);
            cmp("store_count",  64'(store_count),  64'(e.sc));
`ifdef DMEM_BOUNDS_CHECK_EN
            cmp("fault",        64'(fault),        64'(e.flt));
`endif
        end
    end

    function automatic stim_t S(input logic rst, v, mr, mw, rw, m2r, input logic [4:0] rd,
                                input logic [63:0] alu, sd, input logic st, fl);
        stim_t s;
        s = '{rst, v, mr, mw, rw, m2r, rd, alu, sd, st, fl};
        return s;
    endfunction

    function automatic exp_t E(input logic v, rw, input logic [4:0] rd, input logic [63:0] val,
                               rdata, input logic [15:0] sc, input logic flt);
        exp_t e;
        e = '{0, v, rw, rd, val, rdata, sc, flt};
        return e;
    endfunction

    task automatic drive(input stim_t s, input exp_t e);
        reset = s.rst; ex_valid = s.v; ex_mem_read = s.mr; ex_mem_write = s.mw;
        ex_reg_write = s.rw; ex_mem_to_reg = s.m2r; ex_rd = s.rd;
        ex_alu_result = s.alu; ex_store_data = s.sd; stall = s.st; flush = s.fl;
        e.due = cyc + 1;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_mem(input int idx, input logic [63:0] exp);
        cmp($sformatf("memory[%0d]", idx), dut.u_mem.memory[idx], exp);
    endtask

    initial begin
        // Seed memory through stores, then reset: contents must survive, count must clear.
        drive(S(1,0,0,0,0,0,0,0,0,0,0),      E(0,0,0,0,0,0,0));
        drive(S(0,1,0,1,0,0,0,20,17,0,0),    E(1,0,0,20,0,1,0));
        drive(S(0,1,0,1,0,0,0,21,21,0,0),    E(1,0,0,21,0,2,0));
        drive(S(0,1,0,1,0,0,0,22,9,0,0),     E(1,0,0,22,0,3,0));
        drive(S(1,1,0,1,0,0,0,23,5,0,0),     E(0,0,0,0,0,0,0));
        // Loads of preloaded words
        drive(S(0,1,1,0,1,1,2,20,0,0,0),     E(1,1,2,17,17,0,0));
        drive(S(0,1,1,0,1,1,2,21,0,0,0),     E(1,1,2,21,21,0,0));
        // STUR then LDUR same index
        drive(S(0,1,0,1,0,0,0,20,6,0,0),     E(1,0,0,20,0,1,0));
        drive(S(0,1,1,0,1,1,3,20,0,0,0),     E(1,1,3,6,6,1,0));
        // Stalled store for two cycles, then released
        drive(S(0,1,0,1,0,0,0,22,6,1,0),     E(1,1,3,6,6,1,0));
        chk_mem(22, 64'd9);
        drive(S(0,1,0,1,0,0,0,22,6,1,0),     E(1,1,3,6,6,1,0));
        chk_mem(22, 64'd9);
        drive(S(0,1,0,1,0,0,0,22,6,0,0),     E(1,0,0,22,0,2,0));
        chk_mem(22, 64'd6);
        // Flushed load, XZR write, plain ALU result
        drive(S(0,1,1,0,1,1,4,21,0,0,1),     E(0,0,0,0,0,2,0));
        chk_mem(21, 64'd21);
        drive(S(0,1,0,0,1,0,31,64'h55,0,0,0), E(1,0,31,64'h55,0,2,0));
        drive(S(0,1,0,0,1,0,5,64'h1234,0,0,0), E(1,1,5,64'h1234,0,2,0));
        // Read and write together: store only, no writeback, load data zero
        drive(S(0,1,1,1,1,1,6,23,64'hAB,0,0), E(1,0,6,0,0,3,0));
        chk_mem(23, 64'hAB);
        // Address 64: wraps to word 0, or faults when bounds checking is built in
        drive(S(0,1,0,1,0,0,0,64,64'h77,0,0), E(1,0,0,64,0,BC ? 16'd3 : 16'd4,BC));
        if (!BC) chk_mem(0, 64'h77);
        // Address 84 aliases word 20 (holding 6) unless bounds-checked
        drive(S(0,1,1,0,1,1,7,84,0,0,0),
              E(1,!BC,7,BC ? 64'd0 : 64'd6,BC ? 64'd0 : 64'd6,BC ? 16'd3 : 16'd4,BC));
        // Stall and flush together: stall wins, everything holds
        drive(S(0,1,0,1,0,0,0,25,64'h99,1,1),
              E(1,!BC,7,BC ? 64'd0 : 64'd6,BC ? 64'd0 : 64'd6,BC ? 16'd3 : 16'd4,BC));
        drive(S(0,0,0,0,0,0,0,0,0,0,0),      E(0,0,0,0,0,BC ? 16'd3 : 16'd4,BC));
        // Mid-stream reset
        drive(S(1,1,0,1,0,0,0,20,64'hEE,0,0), E(0,0,0,0,0,0,0));
        chk_mem(20, 64'd6);
        drive(S(0,0,0,0,0,0,0,0,0,0,0),      E(0,0,0,0,0,0,0));
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
